// File: rtl/exposure_sequencer.sv
// Exposure/readout sequencer for the camera sensor: erase, timed expose, then
// a row-by-row readout with an ADC strobe per row. Supports single-shot and video modes.
module exposure_sequencer #(
    parameter int N_ROWS      = 2,
    parameter int EXP_W       = 5,
    parameter int EXP_MIN     = 2,
    parameter int EXP_MAX     = 30,
    parameter int EXP_DEFAULT = 2,
    parameter int ERASE_CYC   = 4,
    parameter int TICK_DIV    = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Init,
    input  logic              Exp_increase,
    input  logic              Exp_decrease,
    input  logic              Mode,
    output logic              Erase,
    output logic              Expose,
    output logic [N_ROWS-1:0] NRE,
    output logic              ADC,
    output logic [EXP_W-1:0]  Exp_time,
    output logic              Busy,
    output logic              Frame_done
);

    localparam int CNT_W = EXP_W + $clog2(TICK_DIV);
    localparam int ER_W  = $clog2(ERASE_CYC) + 1;
    localparam int RW    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam logic [N_ROWS-1:0] NRE_ROW0 = ~N_ROWS'(1);

    typedef enum logic [1:0] {IDLE, ERASE, EXPOSE, READ} state_t;

    state_t            state_reg;
    logic              init_prev_reg;
    logic              inc_prev_reg;
    logic              dec_prev_reg;
    logic [ER_W-1:0]   erase_cnt_reg;
    logic [CNT_W-1:0]  exp_cnt_reg;
    logic [RW-1:0]     row_reg;
    logic [1:0]        phase_reg;

    logic              init_rise;
    logic              inc_rise;
    logic              dec_rise;
    logic [CNT_W-1:0]  exp_load;
    logic              row_last;
    logic [RW-1:0]     row_next;
    logic [N_ROWS-1:0] nre_next;

    assign init_rise = Init & ~init_prev_reg;
    assign inc_rise  = Exp_increase & ~inc_prev_reg;
    assign dec_rise  = Exp_decrease & ~dec_prev_reg;

    // Expose length in clocks minus one; the counter runs down to zero.
    assign exp_load  = CNT_W'(Exp_time) * CNT_W'(TICK_DIV) - CNT_W'(1);
    assign row_last  = (row_reg == RW'(N_ROWS - 1));
    assign row_next  = row_reg + RW'(1);

    generate
        for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_row_dec
            assign nre_next[gi] = (row_next != RW'(gi));
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            init_prev_reg <= 1'b0;
            inc_prev_reg  <= 1'b0;
            dec_prev_reg  <= 1'b0;
            erase_cnt_reg <= '0;
            exp_cnt_reg   <= '0;
            row_reg       <= '0;
            phase_reg     <= 2'd0;
            Erase         <= 1'b0;
            Expose        <= 1'b0;
            NRE           <= '1;
            ADC           <= 1'b0;
            Exp_time      <= EXP_W'(EXP_DEFAULT);
            Busy          <= 1'b0;
            Frame_done    <= 1'b0;
        end else begin
            init_prev_reg <= Init;
            inc_prev_reg  <= Exp_increase;
            dec_prev_reg  <= Exp_decrease;

            case (state_reg)
                IDLE: begin
                    if (init_rise) begin
                        state_reg     <= ERASE;
                        Erase         <= 1'b1;
                        Busy          <= 1'b1;
                        erase_cnt_reg <= ER_W'(ERASE_CYC - 1);
                    end else if (inc_rise && !dec_rise && Exp_time < EXP_W'(EXP_MAX)) begin
                        Exp_time <= Exp_time + EXP_W'(1);
                    end else if (dec_rise && !inc_rise && Exp_time > EXP_W'(EXP_MIN)) begin
                        Exp_time <= Exp_time - EXP_W'(1);
                    end
                end

                ERASE: begin
                    if (erase_cnt_reg == '0) begin
                        state_reg   <= EXPOSE;
                        Erase       <= 1'b0;
                        Expose      <= 1'b1;
                        exp_cnt_reg <= exp_load;
                    end else begin
                        erase_cnt_reg <= erase_cnt_reg - ER_W'(1);
                    end
                end

                EXPOSE: begin
                    if (exp_cnt_reg == '0) begin
                        state_reg <= READ;
                        Expose    <= 1'b0;
                        NRE       <= NRE_ROW0;
                        row_reg   <= '0;
                        phase_reg <= 2'd0;
                    end else begin
                        exp_cnt_reg <= exp_cnt_reg - CNT_W'(1);
                    end
                end

                READ: begin
                    // Each row takes three cycles: setup, ADC strobe, hold.
                    case (phase_reg)
                        2'd0: begin
                            ADC       <= 1'b1;
                            phase_reg <= 2'd1;
                        end
                        2'd1: begin
                            ADC        <= 1'b0;
                            phase_reg  <= 2'd2;
                            Frame_done <= row_last;
                        end
                        default: begin
                            phase_reg <= 2'd0;
                            if (row_last) begin
                                Frame_done <= 1'b0;
                                NRE        <= '1;
                                if (Mode) begin
                                    state_reg     <= ERASE;
                                    Erase         <= 1'b1;
                                    erase_cnt_reg <= ER_W'(ERASE_CYC - 1);
                                end else begin
                                    state_reg <= IDLE;
                                    Busy      <= 1'b0;
                                end
                            end else begin
                                row_reg <= row_next;
                                NRE     <= nre_next;
                            end
                        end
                    endcase
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exposure_sequencer.sv
// Directed bench for exposure_sequencer: default instance plus a 4-row,
// tick-divided instance; all driving and sampling happens on falling edges.
module tb_exposure_sequencer;

    logic       Clk;
    logic       Reset;
    logic       Init, Exp_increase, Exp_decrease, Mode;
    logic       Erase, Expose, ADC, Busy, Frame_done;
    logic [1:0] NRE;
    logic [4:0] Exp_time;

    logic       init6, inc6, dec6, mode6;
    logic       erase6, expose6, adc6, busy6, fd6;
    logic [3:0] nre6;
    logic [4:0] exp_time6;

    int checks = 0;
    int passes = 0;

    exposure_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Init(Init), .Exp_increase(Exp_increase),
        .Exp_decrease(Exp_decrease), .Mode(Mode), .Erase(Erase), .Expose(Expose),
        .NRE(NRE), .ADC(ADC), .Exp_time(Exp_time), .Busy(Busy), .Frame_done(Frame_done)
    );

    exposure_sequencer #(.N_ROWS(4), .TICK_DIV(3)) dut6 (
        .Clk(Clk), .Reset(Reset), .Init(init6), .Exp_increase(inc6),
        .Exp_decrease(dec6), .Mode(mode6), .Erase(erase6), .Expose(expose6),
        .NRE(nre6), .ADC(adc6), .Exp_time(exp_time6), .Busy(busy6), .Frame_done(fd6)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            Exp_increase = 1'b1;
            @(negedge Clk);
            Exp_increase = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic pulse_dec(input int n);
        for (int i = 0; i < n; i++) begin
            Exp_decrease = 1'b1;
            @(negedge Clk);
            Exp_decrease = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Init = 0; Exp_increase = 0; Exp_decrease = 0; Mode = 0;
        init6 = 0; inc6 = 0; dec6 = 0; mode6 = 0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({Erase, Expose, NRE, ADC, Frame_done, Busy} !== 7'b0011000)
            $display("FAIL reset_outputs: got %b want %b", {Erase, Expose, NRE, ADC, Frame_done, Busy}, 7'b0011000);
        else passes++;
        checks++;
        if (Exp_time !== 5'd2) $display("FAIL reset_exp_time: got %0d want 2", Exp_time);
        else passes++;
        checks++;
        if ({erase6, expose6, nre6, adc6, fd6, busy6} !== 9'b001111000)
            $display("FAIL reset_outputs6: got %b want %b", {erase6, expose6, nre6, adc6, fd6, busy6}, 9'b001111000);
        else passes++;
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Erase, Busy, NRE} !== 4'b0011) $display("FAIL idle_after_reset: got %b want 0011", {Erase, Busy, NRE});
        else passes++;
        $display("reset: checks=%0d passed=%0d", checks, passes);
    endtask

    // Single-shot frame on the default instance with exposure xt ticks.
    task automatic test_frame(input string name, input int xt);
        logic [1:0] one2;
        logic [6:0] expv;
        int rd;
        int last;
        one2 = 2'b01;
        last = 4 + xt + 6;
        Init = 1'b1;
        for (int k = 1; k <= last + 2; k++) begin
            @(negedge Clk);
            Init = 1'b0;
            rd = k - (5 + xt);
            expv[6] = (k >= 1 && k <= 4);
            expv[5] = (k >= 5 && k <= 4 + xt);
            expv[4:3] = (rd >= 0 && rd < 6) ? ~(one2 << (rd / 3)) : 2'b11;
            expv[2] = (rd >= 0 && rd < 6 && rd % 3 == 1);
            expv[1] = (rd == 5);
            expv[0] = (k >= 1 && k <= last);
            checks++;
            if ({Erase, Expose, NRE, ADC, Frame_done, Busy} !== expv)
                $display("FAIL %s cycle %0d: got %b want %b", name, k, {Erase, Expose, NRE, ADC, Frame_done, Busy}, expv);
            else passes++;
        end
        $display("frame %s: exp=%0d checks=%0d passed=%0d", name, xt, checks, passes);
    endtask

    task automatic test_adjust();
        pulse_inc(1);
        checks++;
        if (Exp_time !== 5'd3) $display("FAIL inc_one: got %0d want 3", Exp_time); else passes++;
        pulse_inc(27);
        checks++;
        if (Exp_time !== 5'd30) $display("FAIL inc_to_max: got %0d want 30", Exp_time); else passes++;
        pulse_inc(7);
        checks++;
        if (Exp_time !== 5'd30) $display("FAIL inc_saturate: got %0d want 30", Exp_time); else passes++;
        pulse_dec(40);
        checks++;
        if (Exp_time !== 5'd2) $display("FAIL dec_saturate: got %0d want 2", Exp_time); else passes++;
        Exp_increase = 1'b1;
        repeat (20) @(negedge Clk);
        Exp_increase = 1'b0;
        @(negedge Clk);
        checks++;
        if (Exp_time !== 5'd3) $display("FAIL inc_held: got %0d want 3", Exp_time); else passes++;
        Exp_increase = 1'b1; Exp_decrease = 1'b1;
        @(negedge Clk);
        Exp_increase = 1'b0; Exp_decrease = 1'b0;
        @(negedge Clk);
        checks++;
        if (Exp_time !== 5'd3) $display("FAIL inc_dec_same: got %0d want 3", Exp_time); else passes++;
        pulse_dec(1);
        checks++;
        if (Exp_time !== 5'd2) $display("FAIL dec_one: got %0d want 2", Exp_time); else passes++;
        $display("adjust: checks=%0d passed=%0d", checks, passes);
    endtask

    task automatic test_busy_ignore();
        Init = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            Init = 1'b0;
            if (k == 5) begin
                checks++;
                if (Expose !== 1'b1) $display("FAIL ignore_in_expose cycle 5: got %b want 1", Expose);
                else passes++;
                Exp_increase = 1'b1;
                Init = 1'b1;
            end
            if (k == 6) begin
                Exp_increase = 1'b0;
                Init = 1'b0;
            end
            checks++;
            if ({Busy, Exp_time} !== {(k <= 12) ? 1'b1 : 1'b0, 5'd2})
                $display("FAIL ignore_busy cycle %0d: got busy=%b exp=%0d want busy=%b exp=2", k, Busy, Exp_time, k <= 12);
            else passes++;
        end
        $display("busy_ignore: checks=%0d passed=%0d", checks, passes);
    endtask

    task automatic test_continuous();
        logic [2:0] expv;
        pulse_inc(1);
        Mode = 1'b1;
        Init = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            @(negedge Clk);
            Init = 1'b0;
            if (k == 30) Mode = 1'b0;
            expv[2] = (k <= 39) && (((k - 1) % 13) < 4);
            expv[1] = (k <= 39) && (k % 13 == 0);
            expv[0] = (k <= 39);
            checks++;
            if ({Erase, Frame_done, Busy} !== expv)
                $display("FAIL continuous cycle %0d: got erase/done/busy=%b want %b", k, {Erase, Frame_done, Busy}, expv);
            else passes++;
        end
        pulse_dec(1);
        $display("continuous: checks=%0d passed=%0d", checks, passes);
    endtask

    task automatic test_async_reset();
        pulse_inc(2);
        Init = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clk);
            Init = 1'b0;
        end
        checks++;
        if ({Expose, Exp_time} !== {1'b1, 5'd4}) $display("FAIL pre_abort: got expose=%b exp=%0d want 1/4", Expose, Exp_time);
        else passes++;
        #1 Reset = 1'b1;
        #1;
        checks++;
        if ({Erase, Expose, NRE, ADC, Frame_done, Busy} !== 7'b0011000)
            $display("FAIL async_abort: got %b want 0011000", {Erase, Expose, NRE, ADC, Frame_done, Busy});
        else passes++;
        checks++;
        if (Exp_time !== 5'd2) $display("FAIL async_exp_time: got %0d want 2", Exp_time); else passes++;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0) $display("FAIL post_reset_idle: got %b want 0", Busy); else passes++;
        test_frame("after_reset", 2);
    endtask

    task automatic test_four_rows();
        logic [3:0] one4;
        logic [8:0] expv;
        int rd;
        int adc_count;
        one4 = 4'b0001;
        adc_count = 0;
        init6 = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge Clk);
            init6 = 1'b0;
            rd = k - 11;
            expv[8] = (k >= 1 && k <= 4);
            expv[7] = (k >= 5 && k <= 10);
            expv[6:3] = (rd >= 0 && rd < 12) ? ~(one4 << (rd / 3)) : 4'b1111;
            expv[2] = (rd >= 0 && rd < 12 && rd % 3 == 1);
            expv[1] = (rd == 11);
            expv[0] = (k >= 1 && k <= 22);
            if (adc6 === 1'b1) adc_count++;
            checks++;
            if ({erase6, expose6, nre6, adc6, fd6, busy6} !== expv)
                $display("FAIL four_rows cycle %0d: got %b want %b", k, {erase6, expose6, nre6, adc6, fd6, busy6}, expv);
            else passes++;
        end
        checks++;
        if (adc_count != 4) $display("FAIL four_rows_adc_count: got %0d want 4", adc_count);
        else passes++;
        $display("four_rows: adc=%0d checks=%0d passed=%0d", adc_count, checks, passes);
    endtask

    initial begin
        test_reset();
        test_frame("basic", 2);
        test_adjust();
        test_busy_ignore();
        test_continuous();
        test_async_reset();
        test_four_rows();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/exposure_sequencer.md
# exposure_sequencer

Parametrised exposure/readout controller for the digital camera sensor. It merges exposure-time adjustment, phase timing and sequencing into one block and generalises them:
- N readout rows instead of a fixed two.
- Configurable exposure range and tick prescaler.
- A continuous (video) mode that re-triggers frames back to back.

It sits between the user-button inputs and the sensor/ADC control lines.

## Interface
Parameters:
- N_ROWS, 2, number of sensor rows read out; one NRE line per row; ≥1
- EXP_W, 5, width of the exposure-time register
- EXP_MIN, 2, lowest exposure setting in ticks; ≥1
- EXP_MAX, 30, highest exposure setting in ticks; < 2**EXP_W
- EXP_DEFAULT, 2, exposure setting after reset; EXP_MIN ≤ EXP_DEFAULT ≤ EXP_MAX
- ERASE_CYC, 4, duration of the erase phase in clocks; ≥1
- TICK_DIV, 1, clocks per exposure tick; ≥1

Ports:
- Clk  in  1  system clock, all state updates on its rising edge
- Reset  in  1  asynchronous, active-high reset
- Init  in  1  start request, rising-edge detected
- Exp_increase  in  1  exposure +1 request, rising-edge detected
- Exp_decrease  in  1  exposure −1 request, rising-edge detected
- Mode  in  1  0 = single shot, 1 = continuous
- Erase  out  1  sensor erase, active high
- Expose  out  1  sensor expose, active high
- NRE  out  N_ROWS  row-read enables, active low; bit k = row k
- ADC  out  1  ADC convert strobe, active high
- Exp_time  out  EXP_W  current exposure setting in ticks
- Busy  out  1  high while a frame is in progress
- Frame_done  out  1  one-cycle pulse in the last readout cycle

## Operation
- All outputs are registered. Reset values:
  - Erase=0, Expose=0, NRE=all ones, ADC=0.
  - Busy=0, Frame_done=0, Exp_time=EXP_DEFAULT.
  - Edge-detect history registers = 0, so a high input at the first edge after reset counts as a rising edge.
- States: IDLE, ERASE, EXPOSE, READ.
- IDLE:
  - A rising edge on Init moves the block to ERASE.
  - Exp_increase/Exp_decrease rising edges adjust Exp_time by ±1, saturating at EXP_MAX/EXP_MIN.
  - Simultaneous increase and decrease edges: no change.
  - An input held high counts as one step.
- ERASE: Erase=1 for exactly ERASE_CYC cycles, then EXPOSE.
- EXPOSE:
  - Expose=1 for exactly Exp_time×TICK_DIV cycles, then READ.
  - Exp_time is frozen from Init acceptance until the return to IDLE.
  - Adjust requests outside IDLE are discarded, not queued.
- READ:
  - Rows 0..N_ROWS−1 are read in order, 3 cycles per row.
  - NRE[k]=0 for all 3 cycles; ADC=1 on the middle cycle only.
  - At most one NRE bit is low at any time.
- Frame_done=1 during the final READ cycle. Then:
  - If Mode=1 on that cycle, go to ERASE with no idle gap.
  - Otherwise go to IDLE.
- Busy=1 in ERASE, EXPOSE and READ.
- Init edges while Busy are ignored.
- Mode changes take effect only at the end-of-frame decision.
- Exposure counter width: EXP_W + clog2(TICK_DIV). There is no wrap; the counter is reloaded at each EXPOSE entry.
- Reset mid-frame aborts immediately and asynchronously to the reset values; Exp_time also returns to EXP_DEFAULT.

## Timing
- Init edge sampled at edge t → Erase and Busy high from cycle t+1 (1-cycle latency).
- Frame length = ERASE_CYC + Exp_time×TICK_DIV + 3×N_ROWS cycles.
- In single mode, Busy falls the cycle after Frame_done.
- The earliest accepted re-Init is sampled at the edge that ends the Frame_done cycle + 1 (Busy=0 in that cycle).
- Exposure adjust: the edge is sampled at edge t; the new Exp_time is visible from cycle t+1.

## Test plan
1. Defaults, reset, Init pulse at cycle 0 → required response:
   - Erase cycles 1–4, Expose cycles 5–6.
   - NRE=2'b10 cycles 7–9 with ADC at 8; NRE=2'b01 cycles 10–12 with ADC at 11.
   - Frame_done at 12, Busy cycles 1–12, IDLE at 13.
2. 35 Exp_increase pulses → Exp_time 2→30, then holds at 30. 40 Exp_decrease pulses → holds at 2. Exp_increase held high 20 cycles → exactly +1.
3. Exp_increase and Init during EXPOSE → Exp_time unchanged, no second frame. After the frame, Exp_time=2 and no late increment occurs.
4. Mode=1, Init once, Exp_time=3 → frames repeat every 4+3+6=13 cycles, with Erase high the cycle after each Frame_done. Clear Mode mid-frame → that frame completes, then IDLE.
5. Reset asserted asynchronously mid-EXPOSE (between edges) → all outputs at reset values immediately, Exp_time=EXP_DEFAULT. A new Init after deassert gives the normal scenario-1 sequence.
6. N_ROWS=4, TICK_DIV=3, Exp_time=2 → Expose high 6 cycles. NRE walks 1110, 1101, 1011, 0111, each 3 cycles with one ADC pulse (4 ADC pulses total).
